rotate_lut: RTL and testbench
=============================

Name: rotate_lut

Overview:
- Responder side of the rotator's twiddle lookup interface: accepts `rot_addr` from a `rotate` instance and returns `rot_data` = {cos, sin} for that phase.
- Stores only a quarter-wave sine table, N/4+1 entries where N = 2^ROTATE_WIDTH, and rebuilds full-circle cos/sin using quadrant symmetry.
- The table is loaded at run time over a valid/ready stream from a host or boot loader, then served with fixed 1-cycle read latency.

Parameters:
- ROTATE_WIDTH, 9, phase address width; N = 2^ROTATE_WIDTH points per full circle; legal range ≥ 3.
- DATA_WIDTH, 16, width of each cos/sin component, signed Q1.(DATA_WIDTH-1).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  host presents a table entry.
- load_data  in  DATA_WIDTH  entry value Q[k], non-negative, ≤ 2^(DATA_WIDTH-1)-1.
- load_ready  out  1  block accepts an entry this cycle.
- reload  in  1  single-cycle pulse: discard the table and restart loading.
- table_ready  out  1  table complete, lookups valid.
- rot_addr  in  ROTATE_WIDTH  phase index, angle = 2π·rot_addr/N.
- rot_data  out  2*DATA_WIDTH  {cos[2*DW-1:DW], sin[DW-1:0]}.

Behaviour:
- Reset values (async, reset=0): state=LOAD, load count=0, load_ready=0 during reset, table_ready=0, rot_data=0. Table storage is not cleared.
- States: LOAD, RUN.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1 writes Q[count]=load_data and increments count.
  - The write with count==N/4 (entry N/4+1) transitions to RUN on the next edge; count returns to 0.
  - rot_data is forced to 0 every cycle in LOAD.
- RUN:
  - load_ready=0; load_valid is ignored; table_ready=1.
  - rot_addr sampled at edge t gives rot_data valid after edge t (1-cycle registered latency), every cycle, no bubbles.
- reload=1 in any state: next state LOAD, count=0, table_ready=0.
  - A load_valid in the same cycle is discarded; reload wins.
  - rot_data returns 0 from the cycle after reload.
- Reset mid-load: count restarts at 0; the host must resend all entries.
- Lookup decode: quad=rot_addr[W-1:W-2], idx=rot_addr[W-3:0], Qa=Q[idx], Qb=Q[N/4-idx].
  - quad0: sin=Qa, cos=Qb.
  - quad1: sin=Qb, cos=-Qa.
  - quad2: sin=-Qa, cos=-Qb.
  - quad3: sin=-Qb, cos=Qa.
- Arithmetic:
  - Negation is two's complement at DATA_WIDTH; no overflow, since entries ≤ max positive.
  - idx=0 reads Qb=Q[N/4], the extra entry.
  - Two table reads per cycle, combinational address and registered output.
- No back-pressure on the lookup side; rot_addr is not qualified.

Test Plan:
- Load sequence (W=9, N=512): after reset release, drive 129 entries Q[k]=round(32767·sin(πk/256)) back-to-back -> load_ready=1 throughout; table_ready rises exactly one cycle after the 129th accept.
- Quadrant lookups with rot_addr=0,64,128,256,448 on consecutive cycles -> rot_data = 0x7FFF0000, 0x5A825A82, 0x00007FFF, 0x80010000, 0x5A82A57E, each one cycle after its address.
- Full sweep: rot_addr 0..511 streamed -> every output matches the behavioural model; cos²+sin² within ±2 LSB·2^15 of 32767².
- Gapped load: load_valid toggling 1/0 -> only valid cycles counted; table_ready asserts after the 129th valid; load_valid after table_ready has no effect on lookups.
- Reload then a partial load of 50 entries -> table_ready=0 and rot_data=0 throughout. Reload coincident with load_valid -> that entry not counted (129 more needed).
- Async reset asserted mid-load (entry 70) between clock edges -> outputs reach reset values immediately; a full 129-entry reload is required before table_ready=1.

Source files
------------

// File: rtl/rotate_lut_if.sv
// Table-load stream and twiddle lookup signals shared by the host/rotator side
// (master) and the quarter-wave table responder (slave).
interface rotate_lut_if #(
    parameter int ROTATE_WIDTH = 9,
    parameter int DATA_WIDTH   = 16
);
    logic                      load_valid;
    logic [DATA_WIDTH-1:0]     load_data;
    logic                      load_ready;
    logic                      reload;
    logic                      table_ready;
    logic [ROTATE_WIDTH-1:0]   rot_addr;
    logic [2*DATA_WIDTH-1:0]   rot_data;

    modport master (
        output load_valid, load_data, reload, rot_addr,
        input  load_ready, table_ready, rot_data
    );

    modport slave (
        input  load_valid, load_data, reload, rot_addr,
        output load_ready, table_ready, rot_data
    );
endinterface

// File: rtl/rotate_lut.sv
// Quarter-wave sine table loaded over a valid/ready stream, served as full-circle
// {cos, sin} twiddles through quadrant symmetry with one cycle of read latency.
module rotate_lut #(
    parameter int ROTATE_WIDTH = 9,
    parameter int DATA_WIDTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    rotate_lut_if.slave bus
);
    localparam int N  = 1 << ROTATE_WIDTH;
    localparam int QN = N / 4;
    localparam int CW = ROTATE_WIDTH - 1;
    localparam logic [CW-1:0] QN_C = CW'(QN);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state_r;
    logic [CW-1:0]            count_r;
    logic                     load_ready_r;
    logic                     table_ready_r;
    logic [2*DATA_WIDTH-1:0]  rot_data_r;
    logic [DATA_WIDTH-1:0]    table_r [0:QN];

    logic                     wr_en_s;
    logic [1:0]               quad_s;
    logic [CW-1:0]            idx_a_s;
    logic [CW-1:0]            idx_b_s;
    logic [DATA_WIDTH-1:0]    qa_s;
    logic [DATA_WIDTH-1:0]    qb_s;
    logic [DATA_WIDTH-1:0]    cos_s;
    logic [DATA_WIDTH-1:0]    sin_s;

    // Entries are never above max positive, so this cannot overflow.
    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
        return {DATA_WIDTH{1'b0}} - v;
    endfunction

    // Ready is only advertised in LOAD; a coincident reload discards the entry.
    assign wr_en_s = bus.load_valid & load_ready_r & ~bus.reload;

    // Quadrant decode: the two table reads (phase and its complement) rebuild cos/sin.
    always_comb begin
        quad_s  = bus.rot_addr[ROTATE_WIDTH-1 -: 2];
        idx_a_s = {1'b0, bus.rot_addr[ROTATE_WIDTH-3:0]};
        idx_b_s = QN_C - idx_a_s;
        qa_s    = table_r[idx_a_s];
        qb_s    = table_r[idx_b_s];
        case (quad_s)
            2'd0: begin sin_s = qa_s;          cos_s = qb_s;          end
            2'd1: begin sin_s = qb_s;          cos_s = negate(qa_s);  end
            2'd2: begin sin_s = negate(qa_s);  cos_s = negate(qb_s);  end
            2'd3: begin sin_s = negate(qb_s);  cos_s = qa_s;          end
            default: begin sin_s = {DATA_WIDTH{1'b0}}; cos_s = {DATA_WIDTH{1'b0}}; end
        endcase
    end

    // Table storage survives reset; it is simply rewritten by the next load.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            table_r[count_r] <= bus.load_data;
        end
    end

    // Load/run controller with registered handshake and lookup outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= LOAD;
            count_r       <= {CW{1'b0}};
            load_ready_r  <= 1'b0;
            table_ready_r <= 1'b0;
            rot_data_r    <= {(2*DATA_WIDTH){1'b0}};
        end else if (bus.reload) begin
            state_r       <= LOAD;
            count_r       <= {CW{1'b0}};
            load_ready_r  <= 1'b1;
            table_ready_r <= 1'b0;
            rot_data_r    <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            case (state_r)
                LOAD: begin
                    load_ready_r <= 1'b1;
                    rot_data_r   <= {(2*DATA_WIDTH){1'b0}};
                    if (wr_en_s) begin
                        if (count_r == QN_C) begin
                            state_r       <= RUN;
                            count_r       <= {CW{1'b0}};
                            load_ready_r  <= 1'b0;
                            table_ready_r <= 1'b1;
                        end else begin
                            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                RUN: begin
                    load_ready_r  <= 1'b0;
                    table_ready_r <= 1'b1;
                    rot_data_r    <= {cos_s, sin_s};
                end
                default: begin
                    state_r       <= LOAD;
                    count_r       <= {CW{1'b0}};
                    load_ready_r  <= 1'b0;
                    table_ready_r <= 1'b0;
                    rot_data_r    <= {(2*DATA_WIDTH){1'b0}};
                end
            endcase
        end
    end

    assign bus.load_ready  = load_ready_r;
    assign bus.table_ready = table_ready_r;
    assign bus.rot_data    = rot_data_r;
endmodule

// File: tb/tb_rotate_lut.sv
// Randomized bench for rotate_lut: the reference model derives full-circle sin from
// the quarter table by reflection and takes cos as sin shifted by a quarter turn.
module tb_rotate_lut;
    localparam int W  = 9;
    localparam int DW = 16;
    localparam int N  = 1 << W;
    localparam int QN = N / 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    rotate_lut_if #(.ROTATE_WIDTH(W), .DATA_WIDTH(DW)) bus ();

    rotate_lut #(.ROTATE_WIDTH(W), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int tbl [0:QN];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int sin_at(input int k);
        int m = k % N;
        int sgn = 1;
        int r;
        if (m >= 2*QN) begin
            m   = m - 2*QN;
            sgn = -1;
        end
        r = (m <= QN) ? tbl[m] : tbl[2*QN - m];
        return sgn * r;
    endfunction

    function automatic logic [2*DW-1:0] model(input int a);
        int c = sin_at(a + QN);
        int s = sin_at(a);
        return {c[DW-1:0], s[DW-1:0]};
    endfunction

    task automatic fill_random();
        for (int k = 0; k <= QN; k++) tbl[k] = int'($urandom_range(0, 32767));
        tbl[QN] = 32767;
    endtask

    task automatic load_entries(input int count, input bit gapped);
        int   sent = 0;
        int   cyc  = 0;
        logic rdy;
        while (sent < count && cyc < 4*count + 8) begin
            bus.load_valid = gapped ? (cyc % 2 == 0) : 1'b1;
            bus.load_data  = DW'(tbl[sent]);
            rdy = bus.load_ready;
            if (bus.load_valid) check("load_ready", rdy, 1);
            @(posedge clock); #1;
            if (bus.load_valid && rdy) sent++;
            check($sformatf("table_ready@%0d", sent), bus.table_ready, sent == QN + 1);
            check("load_rot_data", bus.rot_data, 0);
            cyc++;
        end
        bus.load_valid = 1'b0;
        check("load_done", sent, count);
    endtask

    task automatic lookup(input int a, input bit noisy);
        bus.rot_addr = a[W-1:0];
        if (noisy) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_data  = DW'($urandom_range(0, 32767));
        end
        @(posedge clock); #1;
        check($sformatf("lookup@%0d", a), bus.rot_data, model(a));
        if (noisy) check("run_load_ready", bus.load_ready, 0);
    endtask

    task automatic async_reset_check(input string tag);
        #3 reset = 1'b0;
        #1;
        check({tag, "_load_ready"},  bus.load_ready, 0);
        check({tag, "_table_ready"}, bus.table_ready, 0);
        check({tag, "_rot_data"},    bus.rot_data, 0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
    endtask

    int          quad_addr [5] = '{0, 64, 128, 256, 448};
    logic [31:0] quad_exp  [5] = '{32'h7FFF0000, 32'h5A825A82, 32'h00007FFF,
                                   32'h80010000, 32'h5A82A57E};

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.reload     = 1'b0;
        bus.rot_addr   = '0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_load_ready",  bus.load_ready, 0);
        check("rst_table_ready", bus.table_ready, 0);
        check("rst_rot_data",    bus.rot_data, 0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        // Sine table, back-to-back load
        for (int k = 0; k <= QN; k++)
            tbl[k] = $rtoi(32767.0 * $sin(3.14159265358979 * k / 256.0) + 0.5);
        load_entries(QN + 1, 1'b0);

        // Quadrant points against fixed constants
        for (int i = 0; i < 5; i++) begin
            lookup(quad_addr[i], 1'b0);
            check($sformatf("quad_const@%0d", quad_addr[i]), bus.rot_data, quad_exp[i]);
        end

        // Full sweep with magnitude check
        for (int a = 0; a < N; a++) begin
            longint c, s, e;
            lookup(a, 1'b0);
            c = longint'($signed(bus.rot_data[2*DW-1:DW]));
            s = longint'($signed(bus.rot_data[DW-1:0]));
            e = c*c + s*s - 64'sd1073676289;
            check($sformatf("norm@%0d", a), (e <= 65536 && e >= -65536), 1);
        end

        async_reset_check("run_reset");

        // Gapped load of a random table, then lookups with stray load_valid
        fill_random();
        load_entries(QN + 1, 1'b1);
        for (int i = 0; i < 200; i++) lookup(int'($urandom_range(0, N - 1)), 1'b1);
        bus.load_valid = 1'b0;

        // Reload pulse from RUN, then a partial load
        bus.reload = 1'b1;
        @(posedge clock); #1;
        bus.reload = 1'b0;
        check("reload_table_ready", bus.table_ready, 0);
        check("reload_rot_data",    bus.rot_data, 0);
        check("reload_load_ready",  bus.load_ready, 1);
        fill_random();
        load_entries(50, 1'b0);

        // Reload coincident with load_valid: that entry must not count
        bus.reload     = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = DW'($urandom_range(0, 32767));
        @(posedge clock); #1;
        bus.reload     = 1'b0;
        bus.load_valid = 1'b0;
        check("reload_coinc_table_ready", bus.table_ready, 0);
        fill_random();
        load_entries(QN + 1, 1'b0);
        for (int i = 0; i < 100; i++) lookup(int'($urandom_range(0, N - 1)), 1'b0);

        // Async reset at entry 70 of a load; full reload required afterwards
        bus.reload = 1'b1;
        @(posedge clock); #1;
        bus.reload = 1'b0;
        fill_random();
        load_entries(70, 1'b0);
        async_reset_check("midload_reset");
        fill_random();
        load_entries(QN + 1, 1'b0);
        lookup(0, 1'b0);
        lookup(QN, 1'b0);
        lookup(2*QN, 1'b0);
        lookup(N - 1, 1'b0);
        for (int i = 0; i < 100; i++) lookup(int'($urandom_range(0, N - 1)), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
